// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer
//   Sequences hardware interrupt entry and RTI for the pipelined core. It
//   freezes fetch and drains the pipeline. It then injects stack micro-ops
//   into the memory stage, overriding the control unit's SP/memory signals
//   while busy.
//     Interrupt: push PC, push flags, load PC from the vector location.
//     RTI:       pop flags, pop PC.
//
// Build option:
//   INT_EDGE_CAPTURE_EN  When defined, a rising edge of int_req sets a pending
//                        latch, including while busy. When undefined, int_req
//                        is level-sensitive and is sampled only in IDLE.
//
// Ports:
//   clk, reset_n       core clock, asynchronous active-low reset
//   int_req            external interrupt request
//   rti_req            RTI decoded in decode stage (1-cycle pulse)
//   mem_ready          data memory finished the current injected access
//   stall_fetch, busy  fetch freeze / sequencer not idle
//   int_ack            1-cycle pulse when an interrupt is accepted
//   inj_*              injected memory-stage micro-op controls
//   inj_vector         constant VECTOR_ADDR
//   pc_load            load PC from memory read data (Mealy on mem_ready)
//   flags_restore      load CCR from memory read data (Mealy on mem_ready)
//
// state      | meaning
// -----------+-----------------------------------------------
// IDLE       | no sequence in progress, pipeline runs normally
// DRAIN      | fetch stalled, waiting for older instructions
// PUSH_PC    | store return PC at --SP
// PUSH_FLAGS | store flags at --SP
// VECTOR     | read handler address from VECTOR_ADDR into PC
// POP_FLAGS  | read flags from SP, SP++
// POP_PC     | read return PC from SP, SP++

module interrupt_sequencer #(
    parameter int                ADDR_W       = 32,
    parameter int                DRAIN_CYCLES = 3,
    parameter logic [ADDR_W-1:0] VECTOR_ADDR  = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              int_req,
    input  logic              rti_req,
    input  logic              mem_ready,
    output logic              stall_fetch,
    output logic              busy,
    output logic              int_ack,
    output logic              inj_valid,
    output logic              inj_mem_write,
    output logic              inj_mem_read,
    output logic [1:0]        inj_sp_op,
    output logic [1:0]        inj_data_sel,
    output logic              inj_addr_sel,
    output logic [ADDR_W-1:0] inj_vector,
    output logic              pc_load,
    output logic              flags_restore
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] DRAIN      = 3'd1;
    localparam logic [2:0] PUSH_PC    = 3'd2;
    localparam logic [2:0] PUSH_FLAGS = 3'd3;
    localparam logic [2:0] VECTOR     = 3'd4;
    localparam logic [2:0] POP_FLAGS  = 3'd5;
    localparam logic [2:0] POP_PC     = 3'd6;

    localparam logic MODE_INT = 1'b0;
    localparam logic MODE_RTI = 1'b1;

    localparam int               CNT_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    logic [2:0]       state, state_nxt;
    logic             mode, mode_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             pending;
    logic             take_rti, take_int;

    // rti_req has priority; a simultaneous interrupt stays pending.
    assign take_rti = (state == IDLE) && rti_req;
    assign take_int = (state == IDLE) && !rti_req && pending;

`ifdef INT_EDGE_CAPTURE_EN
    logic int_prev, int_pend, int_edge;

    assign int_edge = int_req && !int_prev;
    // Include the current edge so acceptance latency matches level mode.
    assign pending  = int_pend || int_edge;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            int_prev <= 1'b0;
            int_pend <= 1'b0;
        end else begin
            int_prev <= int_req;
            if (take_int)
                int_pend <= 1'b0;
            else if (int_edge)
                int_pend <= 1'b1;
        end
    end
`else
    assign pending = int_req;
`endif

    always_comb begin
        state_nxt = state;
        mode_nxt  = mode;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (take_rti) begin
                    state_nxt = DRAIN;
                    mode_nxt  = MODE_RTI;
                    cnt_nxt   = CNT_LOAD;
                end else if (take_int) begin
                    state_nxt = DRAIN;
                    mode_nxt  = MODE_INT;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            DRAIN: begin
                if (cnt == '0)
                    state_nxt = (mode == MODE_INT) ? PUSH_PC : POP_FLAGS;
                else
                    cnt_nxt = cnt - CNT_W'(1);
            end
            PUSH_PC:    if (mem_ready) state_nxt = PUSH_FLAGS;
            PUSH_FLAGS: if (mem_ready) state_nxt = VECTOR;
            VECTOR:     if (mem_ready) state_nxt = IDLE;
            POP_FLAGS:  if (mem_ready) state_nxt = POP_PC;
            POP_PC:     if (mem_ready) state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            mode  <= MODE_INT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            mode  <= mode_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        stall_fetch   = (state != IDLE);
        busy          = (state != IDLE);
        // Counter still holds its load value only in the first DRAIN cycle.
        int_ack       = (state == DRAIN) && (mode == MODE_INT) && (cnt == CNT_LOAD);
        inj_valid     = 1'b0;
        inj_mem_write = 1'b0;
        inj_mem_read  = 1'b0;
        inj_sp_op     = 2'b00;
        inj_data_sel  = 2'b00;
        inj_addr_sel  = 1'b0;
        case (state)
            PUSH_PC: begin
                inj_valid     = 1'b1;
                inj_mem_write = 1'b1;
                inj_sp_op     = 2'b01;
            end
            PUSH_FLAGS: begin
                inj_valid     = 1'b1;
                inj_mem_write = 1'b1;
                inj_sp_op     = 2'b01;
                inj_data_sel  = 2'b01;
            end
            VECTOR: begin
                inj_valid     = 1'b1;
                inj_mem_read  = 1'b1;
                inj_addr_sel  = 1'b1;
            end
            POP_FLAGS, POP_PC: begin
                inj_valid     = 1'b1;
                inj_mem_read  = 1'b1;
                inj_sp_op     = 2'b10;
            end
            default: ;
        endcase
    end

    assign pc_load       = mem_ready && ((state == VECTOR) || (state == POP_PC));
    assign flags_restore = mem_ready && (state == POP_FLAGS);
    assign inj_vector    = VECTOR_ADDR;

endmodule

// File: tb/tb_interrupt_sequencer.sv
module tb_interrupt_sequencer;

    localparam logic [31:0] VEC0 = 32'h0000_0100;

    // Packed observation: {stall, busy, ack, valid, wr, rd, sp[1:0], ds[1:0], as, pc_load, flags_restore}
    localparam logic [12:0] S   = 13'h1000;
    localparam logic [12:0] B   = 13'h0800;
    localparam logic [12:0] ACK = 13'h0400;
    localparam logic [12:0] V   = 13'h0200;
    localparam logic [12:0] WR  = 13'h0100;
    localparam logic [12:0] RD  = 13'h0080;
    localparam logic [12:0] SPO = 13'h0040;
    localparam logic [12:0] SPU = 13'h0020;
    localparam logic [12:0] DSF = 13'h0008;
    localparam logic [12:0] AS  = 13'h0004;
    localparam logic [12:0] PC  = 13'h0002;
    localparam logic [12:0] FR  = 13'h0001;

    localparam logic [12:0] E_DRAIN = S | B;
    localparam logic [12:0] E_ACK   = S | B | ACK;
    localparam logic [12:0] E_PPC   = S | B | V | WR | SPU;
    localparam logic [12:0] E_PFL   = S | B | V | WR | SPU | DSF;
    localparam logic [12:0] E_VEC   = S | B | V | RD | AS;
    localparam logic [12:0] E_POP   = S | B | V | RD | SPO;

    typedef struct {
        string       name;
        logic        i;
        logic        r;
        logic        m;
        logic [12:0] exp;
    } vec_t;

    vec_t vecs[$];

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic int0 = 1'b0, rti0 = 1'b0, mr0 = 1'b0;
    logic int1 = 1'b0, rti1 = 1'b0, mr1 = 1'b0;

    logic        st0, bz0, ack0, iv0, iw0, ir0, ia0, pcl0, fr0;
    logic [1:0]  sp0, ds0;
    logic [31:0] vec0;
    logic        st1, bz1, ack1, iv1, iw1, ir1, ia1, pcl1, fr1;
    logic [1:0]  sp1, ds1;
    logic [31:0] vec1;

    logic [12:0] obs0, obs1;
    assign obs0 = {st0, bz0, ack0, iv0, iw0, ir0, sp0, ds0, ia0, pcl0, fr0};
    assign obs1 = {st1, bz1, ack1, iv1, iw1, ir1, sp1, ds1, ia1, pcl1, fr1};

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    interrupt_sequencer #(.ADDR_W(32), .DRAIN_CYCLES(3), .VECTOR_ADDR(VEC0)) u0 (
        .clk(clk), .reset_n(reset_n), .int_req(int0), .rti_req(rti0), .mem_ready(mr0),
        .stall_fetch(st0), .busy(bz0), .int_ack(ack0), .inj_valid(iv0),
        .inj_mem_write(iw0), .inj_mem_read(ir0), .inj_sp_op(sp0), .inj_data_sel(ds0),
        .inj_addr_sel(ia0), .inj_vector(vec0), .pc_load(pcl0), .flags_restore(fr0)
    );

    interrupt_sequencer #(.ADDR_W(32), .DRAIN_CYCLES(1), .VECTOR_ADDR(32'h0)) u1 (
        .clk(clk), .reset_n(reset_n), .int_req(int1), .rti_req(rti1), .mem_ready(mr1),
        .stall_fetch(st1), .busy(bz1), .int_ack(ack1), .inj_valid(iv1),
        .inj_mem_write(iw1), .inj_mem_read(ir1), .inj_sp_op(sp1), .inj_data_sel(ds1),
        .inj_addr_sel(ia1), .inj_vector(vec1), .pc_load(pcl1), .flags_restore(fr1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input string n, input logic i, input logic r, input logic m,
                       input logic [12:0] e);
        vec_t v;
        v.name = n; v.i = i; v.r = r; v.m = m; v.exp = e;
        vecs.push_back(v);
    endtask

    initial begin
        // Interrupt entry, mem_ready mostly high; rti_req while busy is dropped.
        add("int_idle",        1, 0, 1, 13'h0);
        add("int_drain1",      0, 0, 1, E_ACK);
        add("int_drain2",      0, 0, 1, E_DRAIN);
        add("int_drain3",      0, 0, 1, E_DRAIN);
        add("int_pushpc_wait", 0, 1, 0, E_PPC);
        add("int_pushpc",      0, 0, 1, E_PPC);
        add("int_pushfl",      0, 0, 1, E_PFL);
        add("int_vector",      0, 0, 1, E_VEC | PC);
        add("int_done",        0, 0, 1, 13'h0);
        add("int_rti_dropped", 0, 0, 1, 13'h0);
        // RTI with two wait cycles in POP_FLAGS.
        add("rti_idle",        0, 1, 1, 13'h0);
        add("rti_drain1",      0, 0, 1, E_DRAIN);
        add("rti_drain2",      0, 0, 1, E_DRAIN);
        add("rti_drain3",      0, 0, 0, E_DRAIN);
        add("rti_popf_w1",     0, 0, 0, E_POP);
        add("rti_popf_w2",     0, 0, 0, E_POP);
        add("rti_popf",        0, 0, 1, E_POP | FR);
        add("rti_poppc",       0, 0, 1, E_POP | PC);
        add("rti_done",        0, 0, 1, 13'h0);
        // RTI and interrupt together: RTI first, then the interrupt.
        add("both_idle",       1, 1, 1, 13'h0);
        add("both_drain1",     1, 0, 1, E_DRAIN);
        add("both_drain2",     1, 0, 1, E_DRAIN);
        add("both_drain3",     1, 0, 1, E_DRAIN);
        add("both_popf",       1, 0, 1, E_POP | FR);
        add("both_poppc",      1, 0, 1, E_POP | PC);
        add("both_idle2",      1, 0, 1, 13'h0);
        add("both_ack",        0, 0, 1, E_ACK);
        add("both_drain2b",    0, 0, 1, E_DRAIN);
        add("both_drain3b",    0, 0, 1, E_DRAIN);
        add("both_pushpc",     0, 0, 1, E_PPC);
        add("both_pushfl",     0, 0, 1, E_PFL);
        add("both_vector",     0, 0, 1, E_VEC | PC);
        add("both_done",       0, 0, 1, 13'h0);
        // One-cycle int_req pulse during an RTI sequence.
        add("pulse_rti",       0, 1, 1, 13'h0);
        add("pulse_drain1",    1, 0, 1, E_DRAIN);
        add("pulse_drain2",    0, 0, 1, E_DRAIN);
        add("pulse_drain3",    0, 0, 1, E_DRAIN);
        add("pulse_popf",      0, 0, 1, E_POP | FR);
        add("pulse_poppc",     0, 0, 1, E_POP | PC);
        add("pulse_idle",      0, 0, 1, 13'h0);
`ifdef INT_EDGE_CAPTURE_EN
        add("pulse_ack",       0, 0, 1, E_ACK);
        add("pulse_drain2b",   0, 0, 1, E_DRAIN);
        add("pulse_drain3b",   0, 0, 1, E_DRAIN);
        add("pulse_pushpc",    0, 0, 1, E_PPC);
        add("pulse_pushfl",    0, 0, 1, E_PFL);
        add("pulse_vector",    0, 0, 1, E_VEC | PC);
        add("pulse_done",      0, 0, 1, 13'h0);
`else
        add("pulse_lost1",     0, 0, 1, 13'h0);
        add("pulse_lost2",     0, 0, 1, 13'h0);
`endif

        repeat (3) @(negedge clk);
        check("reset_outputs", {19'h0, obs0}, 32'h0);
        check("reset_vector",  vec0, VEC0);
        check("reset_vector1", vec1, 32'h0);
        reset_n = 1'b1;

        for (int k = 0; k < vecs.size(); k++) begin
            @(posedge clk);
            #1;
            int0 = vecs[k].i;
            rti0 = vecs[k].r;
            mr0  = vecs[k].m;
            @(negedge clk);
            check(vecs[k].name, {19'h0, obs0}, {19'h0, vecs[k].exp});
        end

        // Reset asserted while PUSH_FLAGS waits on mem_ready.
        @(posedge clk); #1; int0 = 1'b1; rti0 = 1'b0; mr0 = 1'b0;
        @(posedge clk); #1; int0 = 1'b0;
        repeat (3) @(posedge clk);
        #1; mr0 = 1'b1;
        @(posedge clk); #1; mr0 = 1'b0;
        @(negedge clk);
        check("rst_pre_pushfl", {19'h0, obs0}, {19'h0, E_PFL});
        #2; reset_n = 1'b0;
        #1;
        check("rst_async_outputs", {19'h0, obs0}, 32'h0);
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk);
        check("rst_after_release", {19'h0, obs0}, 32'h0);
        check("rst_busy_low", {31'h0, bz0}, 32'h0);

        // DRAIN_CYCLES=1 instance: PUSH_PC in second busy cycle.
        @(posedge clk); #1; int1 = 1'b1; mr1 = 1'b1;
        @(posedge clk); #1; int1 = 1'b0;
        @(negedge clk);
        check("dc1_drain_ack", {19'h0, obs1}, {19'h0, E_ACK});
        @(negedge clk);
        check("dc1_pushpc", {19'h0, obs1}, {19'h0, E_PPC});
        @(negedge clk);
        check("dc1_pushfl", {19'h0, obs1}, {19'h0, E_PFL});
        @(negedge clk);
        check("dc1_vector", {19'h0, obs1}, {19'h0, E_VEC | PC});
        @(negedge clk);
        check("dc1_idle", {19'h0, obs1}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
